// File: rtl/axi4_lite_slave_regfile_if.sv
// AXI4-Lite bus bundle between a master and the register-file slave.
// The master drives addresses, data and response-ready; the slave drives the remaining handshake signals.
interface axi4_lite_slave_regfile_if #(
  parameter int ADDRESS    = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDRESS-1:0]      S_AWADDR;
  logic                    S_AWVALID;
  logic                    S_AWREADY;
  logic [DATA_WIDTH-1:0]   S_WDATA;
  logic [DATA_WIDTH/8-1:0] S_WSTRB;
  logic                    S_WVALID;
  logic                    S_WREADY;
  logic [1:0]              S_BRESP;
  logic                    S_BVALID;
  logic                    S_BREADY;
  logic [ADDRESS-1:0]      S_ARADDR;
  logic                    S_ARVALID;
  logic                    S_ARREADY;
  logic [DATA_WIDTH-1:0]   S_RDATA;
  logic [1:0]              S_RRESP;
  logic                    S_RVALID;
  logic                    S_RREADY;

  modport master (
    output S_AWADDR, S_AWVALID, S_WDATA, S_WSTRB, S_WVALID, S_BREADY,
           S_ARADDR, S_ARVALID, S_RREADY,
    input  S_AWREADY, S_WREADY, S_BRESP, S_BVALID, S_ARREADY, S_RDATA, S_RRESP, S_RVALID
  );

  modport slave (
    input  S_AWADDR, S_AWVALID, S_WDATA, S_WSTRB, S_WVALID, S_BREADY,
           S_ARADDR, S_ARVALID, S_RREADY,
    output S_AWREADY, S_WREADY, S_BRESP, S_BVALID, S_ARREADY, S_RDATA, S_RRESP, S_RVALID
  );
endinterface

// File: rtl/axi4_lite_slave_regfile.sv
// AXI4-Lite slave exposing NUM_REGS word registers, with independent write (AW/W/B) and read (AR/R) engines.
// All register contents are exported flat on regs_q.
module axi4_lite_slave_regfile #(
  parameter int ADDRESS    = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 8
) (
  input  logic                           ACLK,
  input  logic                           ARESETN,
  axi4_lite_slave_regfile_if.slave       s_axi,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_q
);
  localparam int IDX_W     = $clog2(NUM_REGS);
  localparam int NUM_BYTES = DATA_WIDTH / 8;
  localparam int TAG_LSB   = IDX_W + 2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    WR_ACCEPT = 2'd0,
    WR_COMMIT = 2'd1,
    WR_RESP   = 2'd2
  } wr_state_t;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_DATA = 1'b1
  } rd_state_t;

  wr_state_t             wr_state_reg, wr_state_next;
  rd_state_t             rd_state_reg, rd_state_next;
  logic                  rst_done_reg;
  logic                  aw_held_reg, w_held_reg;
  logic [ADDRESS-1:2]    awaddr_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic [NUM_BYTES-1:0]  wstrb_reg;
  logic [1:0]            bresp_reg;
  logic [DATA_WIDTH-1:0] rdata_reg;
  logic [1:0]            rresp_reg;

  logic                  awready, wready, bvalid, arready, rvalid;
  logic                  aw_fire, w_fire, ar_fire;
  logic                  wr_commit, wr_in_range, ar_in_range;
  logic [IDX_W-1:0]      wr_idx, ar_idx;
  logic [DATA_WIDTH-1:0] reg_words [NUM_REGS];
  logic                  unused_addr_lsbs;

  assign aw_fire     = s_axi.S_AWVALID && awready;
  assign w_fire      = s_axi.S_WVALID && wready;
  assign ar_fire     = s_axi.S_ARVALID && arready;
  assign wr_commit   = (wr_state_reg == WR_COMMIT);
  assign wr_idx      = awaddr_reg[TAG_LSB-1:2];
  assign wr_in_range = (awaddr_reg[ADDRESS-1:TAG_LSB] == '0);
  assign ar_idx      = s_axi.S_ARADDR[TAG_LSB-1:2];
  assign ar_in_range = (s_axi.S_ARADDR[ADDRESS-1:TAG_LSB] == '0);
  // Byte offsets within a word carry no meaning for word registers.
  assign unused_addr_lsbs = ^{s_axi.S_AWADDR[1:0], s_axi.S_ARADDR[1:0]};

  // READYs stay low until the first edge after reset is released.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) rst_done_reg <= 1'b0;
    else          rst_done_reg <= 1'b1;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) wr_state_reg <= WR_ACCEPT;
    else          wr_state_reg <= wr_state_next;
  end

  always_comb begin
    wr_state_next = wr_state_reg;
    case (wr_state_reg)
      WR_ACCEPT: if ((aw_held_reg || aw_fire) && (w_held_reg || w_fire)) wr_state_next = WR_COMMIT;
      WR_COMMIT: wr_state_next = WR_RESP;
      WR_RESP:   if (s_axi.S_BREADY) wr_state_next = WR_ACCEPT;
      default:   wr_state_next = WR_ACCEPT;
    endcase
  end

  always_comb begin
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    case (wr_state_reg)
      WR_ACCEPT: begin
        awready = rst_done_reg && !aw_held_reg;
        wready  = rst_done_reg && !w_held_reg;
      end
      WR_RESP: bvalid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_held_reg <= 1'b0;
      w_held_reg  <= 1'b0;
      awaddr_reg  <= '0;
      wdata_reg   <= '0;
      wstrb_reg   <= '0;
      bresp_reg   <= RESP_OKAY;
    end else begin
      if (aw_fire) begin
        aw_held_reg <= 1'b1;
        awaddr_reg  <= s_axi.S_AWADDR[ADDRESS-1:2];
      end
      if (w_fire) begin
        w_held_reg <= 1'b1;
        wdata_reg  <= s_axi.S_WDATA;
        wstrb_reg  <= s_axi.S_WSTRB;
      end
      if (wr_commit) begin
        aw_held_reg <= 1'b0;
        w_held_reg  <= 1'b0;
        bresp_reg   <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  // One word per register; each byte lane updates only when its strobe is set.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    logic [DATA_WIDTH-1:0] word_reg;
    always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
        word_reg <= '0;
      end else if (wr_commit && wr_in_range && (wr_idx == IDX_W'(gi))) begin
        for (int b = 0; b < NUM_BYTES; b++) begin
          if (wstrb_reg[b]) word_reg[b*8 +: 8] <= wdata_reg[b*8 +: 8];
        end
      end
    end
    assign reg_words[gi] = word_reg;
    assign regs_q[gi*DATA_WIDTH +: DATA_WIDTH] = word_reg;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) rd_state_reg <= RD_IDLE;
    else          rd_state_reg <= rd_state_next;
  end

  always_comb begin
    rd_state_next = rd_state_reg;
    case (rd_state_reg)
      RD_IDLE: if (ar_fire) rd_state_next = RD_DATA;
      RD_DATA: if (s_axi.S_RREADY) rd_state_next = RD_IDLE;
      default: rd_state_next = RD_IDLE;
    endcase
  end

  always_comb begin
    arready = 1'b0;
    rvalid  = 1'b0;
    case (rd_state_reg)
      RD_IDLE: arready = rst_done_reg;
      RD_DATA: rvalid  = 1'b1;
      default: ;
    endcase
  end

  // Capture samples the pre-edge register value, so a same-edge commit is not visible.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rdata_reg <= '0;
      rresp_reg <= RESP_OKAY;
    end else if (ar_fire) begin
      rdata_reg <= ar_in_range ? reg_words[ar_idx] : '0;
      rresp_reg <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
    end
  end

  assign s_axi.S_AWREADY = awready;
  assign s_axi.S_WREADY  = wready;
  assign s_axi.S_BVALID  = bvalid;
  assign s_axi.S_BRESP   = bresp_reg;
  assign s_axi.S_ARREADY = arready;
  assign s_axi.S_RVALID  = rvalid;
  assign s_axi.S_RDATA   = rdata_reg;
  assign s_axi.S_RRESP   = rresp_reg;
endmodule

// File: tb/tb_axi4_lite_slave_regfile.sv
// Randomized self-checking bench for axi4_lite_slave_regfile against a word-array reference model.
// Prints one line per bus transaction and a final pass count.
module tb_axi4_lite_slave_regfile;
  localparam int NUM_REGS = 8;

  logic ACLK = 1'b0;
  logic ARESETN = 1'b0;
  logic [NUM_REGS*32-1:0] regs_q;

  int checks_total  = 0;
  int checks_passed = 0;
  logic [31:0] model_regs [NUM_REGS];

  axi4_lite_slave_regfile_if #(.ADDRESS(32), .DATA_WIDTH(32)) bus ();

  axi4_lite_slave_regfile #(
    .ADDRESS(32), .DATA_WIDTH(32), .NUM_REGS(NUM_REGS)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .s_axi(bus), .regs_q(regs_q)
  );

  always #5 ACLK = ~ACLK;

  // Reference model: plain word array, byte-masked writes, bounds from the register count.
  function automatic logic in_range(input logic [31:0] addr);
    return addr < NUM_REGS * 4;
  endfunction

  function automatic void model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    if (in_range(addr))
      for (int b = 0; b < 4; b++)
        if (strb[b]) model_regs[addr / 4][b*8 +: 8] = data[b*8 +: 8];
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    return in_range(addr) ? model_regs[addr / 4] : 32'h0;
  endfunction

  function automatic logic [1:0] model_resp(input logic [31:0] addr);
    return in_range(addr) ? 2'b00 : 2'b10;
  endfunction

  function automatic logic [NUM_REGS*32-1:0] model_flat();
    logic [NUM_REGS*32-1:0] f;
    for (int i = 0; i < NUM_REGS; i++) f[i*32 +: 32] = model_regs[i];
    return f;
  endfunction

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp, output int b_wait);
    int n;
    logic aw_go, w_go;
    bus.S_AWADDR = addr; bus.S_AWVALID = 1'b1;
    bus.S_WDATA = data; bus.S_WSTRB = strb; bus.S_WVALID = 1'b1;
    bus.S_BREADY = 1'b1;
    n = 0;
    while ((bus.S_AWVALID || bus.S_WVALID) && n < 50) begin
      aw_go = bus.S_AWVALID && bus.S_AWREADY;
      w_go  = bus.S_WVALID && bus.S_WREADY;
      tick();
      if (aw_go) bus.S_AWVALID = 1'b0;
      if (w_go)  bus.S_WVALID = 1'b0;
      n++;
    end
    bus.S_AWVALID = 1'b0;
    bus.S_WVALID  = 1'b0;
    b_wait = 0;
    while (!bus.S_BVALID && b_wait < 50) begin
      tick();
      b_wait++;
    end
    resp = bus.S_BRESP;
    checks_total++;
    if (bus.S_BVALID !== 1'b1) $display("FAIL write_timeout addr=%h BVALID=%b required 1", addr, bus.S_BVALID);
    else checks_passed++;
    tick();
    bus.S_BREADY = 1'b0;
    $display("WR addr=%h data=%h strb=%h bresp=%b b_wait=%0d", addr, data, strb, resp, b_wait);
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp,
                          output int r_wait);
    int n;
    logic ar_go;
    bus.S_ARADDR = addr; bus.S_ARVALID = 1'b1; bus.S_RREADY = 1'b1;
    n = 0;
    ar_go = 1'b0;
    while (!ar_go && n < 50) begin
      ar_go = bus.S_ARREADY;
      tick();
      n++;
    end
    bus.S_ARVALID = 1'b0;
    r_wait = 0;
    while (!bus.S_RVALID && r_wait < 50) begin
      tick();
      r_wait++;
    end
    data = bus.S_RDATA;
    resp = bus.S_RRESP;
    checks_total++;
    if (bus.S_RVALID !== 1'b1) $display("FAIL read_timeout addr=%h RVALID=%b required 1", addr, bus.S_RVALID);
    else checks_passed++;
    tick();
    bus.S_RREADY = 1'b0;
    $display("RD addr=%h rdata=%h rresp=%b r_wait=%0d", addr, data, resp, r_wait);
  endtask

  task automatic test_reset();
    bus.S_AWADDR = '0; bus.S_AWVALID = 1'b0; bus.S_WDATA = '0; bus.S_WSTRB = '0; bus.S_WVALID = 1'b0;
    bus.S_BREADY = 1'b0; bus.S_ARADDR = '0; bus.S_ARVALID = 1'b0; bus.S_RREADY = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) model_regs[i] = 32'h0;
    ARESETN = 1'b0;
    #22;
    checks_total++;
    if ({bus.S_AWREADY, bus.S_WREADY, bus.S_BVALID, bus.S_ARREADY, bus.S_RVALID} !== 5'b0)
      $display("FAIL reset_handshake got=%b required 00000",
               {bus.S_AWREADY, bus.S_WREADY, bus.S_BVALID, bus.S_ARREADY, bus.S_RVALID});
    else checks_passed++;
    checks_total++;
    if ({bus.S_BRESP, bus.S_RRESP, bus.S_RDATA} !== 36'h0 || regs_q !== model_flat())
      $display("FAIL reset_payload bresp=%b rresp=%b rdata=%h regs_q=%h required all zero",
               bus.S_BRESP, bus.S_RRESP, bus.S_RDATA, regs_q);
    else checks_passed++;
    @(negedge ACLK);
    ARESETN = 1'b1;
    #1;
    checks_total++;
    if ({bus.S_AWREADY, bus.S_WREADY, bus.S_ARREADY} !== 3'b000)
      $display("FAIL ready_before_edge got=%b required 000", {bus.S_AWREADY, bus.S_WREADY, bus.S_ARREADY});
    else checks_passed++;
    tick();
    checks_total++;
    if ({bus.S_AWREADY, bus.S_WREADY, bus.S_ARREADY} !== 3'b111)
      $display("FAIL ready_after_edge got=%b required 111", {bus.S_AWREADY, bus.S_WREADY, bus.S_ARREADY});
    else checks_passed++;
  endtask

  task automatic test_write_same_cycle();
    logic [1:0] resp;
    logic [31:0] data;
    int wait_cycles;
    axi_write(32'h04, 32'hDEADBEEF, 4'hF, resp, wait_cycles);
    model_write(32'h04, 32'hDEADBEEF, 4'hF);
    checks_total++;
    if (resp !== 2'b00 || wait_cycles !== 1)
      $display("FAIL basic_write bresp=%b b_wait=%0d required bresp=00 b_wait=1", resp, wait_cycles);
    else checks_passed++;
    axi_read(32'h04, data, resp, wait_cycles);
    checks_total++;
    if (data !== 32'hDEADBEEF || resp !== 2'b00 || wait_cycles !== 0)
      $display("FAIL basic_read rdata=%h rresp=%b r_wait=%0d required DEADBEEF/00/0", data, resp, wait_cycles);
    else checks_passed++;
  endtask

  task automatic test_w_before_aw();
    logic [31:0] old_word;
    old_word = model_regs[2];
    bus.S_WDATA = 32'h12345678; bus.S_WSTRB = 4'hF; bus.S_WVALID = 1'b1; bus.S_BREADY = 1'b1;
    tick();
    bus.S_WVALID = 1'b0;
    checks_total++;
    if (bus.S_WREADY !== 1'b0 || bus.S_AWREADY !== 1'b1)
      $display("FAIL w_held_ready wready=%b awready=%b required 0/1", bus.S_WREADY, bus.S_AWREADY);
    else checks_passed++;
    tick();
    checks_total++;
    if (regs_q[2*32 +: 32] !== old_word || bus.S_BVALID !== 1'b0)
      $display("FAIL w_only_no_write reg2=%h bvalid=%b required %h/0", regs_q[2*32 +: 32], bus.S_BVALID, old_word);
    else checks_passed++;
    bus.S_AWADDR = 32'h08; bus.S_AWVALID = 1'b1;
    tick();
    bus.S_AWVALID = 1'b0;
    checks_total++;
    if (regs_q[2*32 +: 32] !== old_word)
      $display("FAIL write_too_early reg2=%h required %h", regs_q[2*32 +: 32], old_word);
    else checks_passed++;
    tick();
    model_write(32'h08, 32'h12345678, 4'hF);
    checks_total++;
    if (regs_q[2*32 +: 32] !== 32'h12345678 || bus.S_BVALID !== 1'b1 || bus.S_BRESP !== 2'b00)
      $display("FAIL w_before_aw_commit reg2=%h bvalid=%b bresp=%b required 12345678/1/00",
               regs_q[2*32 +: 32], bus.S_BVALID, bus.S_BRESP);
    else checks_passed++;
    tick();
    bus.S_BREADY = 1'b0;
    $display("WR addr=00000008 data=12345678 strb=f (W first) bresp=00");
  endtask

  task automatic test_strobe();
    logic [1:0] resp;
    logic [31:0] data;
    int wait_cycles;
    axi_write(32'h04, 32'hDEADBEEF, 4'hF, resp, wait_cycles);
    model_write(32'h04, 32'hDEADBEEF, 4'hF);
    axi_write(32'h04, 32'h00AA0000, 4'b0100, resp, wait_cycles);
    model_write(32'h04, 32'h00AA0000, 4'b0100);
    axi_read(32'h04, data, resp, wait_cycles);
    checks_total++;
    if (data !== 32'hDEAABEEF || resp !== 2'b00)
      $display("FAIL strobe_merge rdata=%h rresp=%b required DEAABEEF/00", data, resp);
    else checks_passed++;
    axi_write(32'h04, 32'hFFFFFFFF, 4'b0000, resp, wait_cycles);
    checks_total++;
    if (resp !== 2'b00 || regs_q !== model_flat())
      $display("FAIL zero_strobe bresp=%b regs_q=%h required 00/%h", resp, regs_q, model_flat());
    else checks_passed++;
  endtask

  task automatic test_out_of_range();
    logic [1:0] resp;
    logic [31:0] data;
    int wait_cycles;
    axi_write(32'h40, 32'hCAFEF00D, 4'hF, resp, wait_cycles);
    checks_total++;
    if (resp !== 2'b10 || regs_q !== model_flat())
      $display("FAIL oor_write bresp=%b regs_q=%h required 10/%h", resp, regs_q, model_flat());
    else checks_passed++;
    axi_read(32'h40, data, resp, wait_cycles);
    checks_total++;
    if (data !== 32'h0 || resp !== 2'b10)
      $display("FAIL oor_read rdata=%h rresp=%b required 00000000/10", data, resp);
    else checks_passed++;
  endtask

  task automatic test_collision();
    logic [1:0] resp;
    logic [31:0] data;
    int wait_cycles;
    axi_write(32'h00, 32'h0, 4'hF, resp, wait_cycles);
    model_write(32'h00, 32'h0, 4'hF);
    bus.S_AWADDR = 32'h00; bus.S_WDATA = 32'h5; bus.S_WSTRB = 4'hF;
    bus.S_AWVALID = 1'b1; bus.S_WVALID = 1'b1; bus.S_BREADY = 1'b0;
    tick();
    bus.S_AWVALID = 1'b0; bus.S_WVALID = 1'b0;
    bus.S_ARADDR = 32'h00; bus.S_ARVALID = 1'b1; bus.S_RREADY = 1'b0;
    tick();
    bus.S_ARVALID = 1'b0;
    checks_total++;
    if (bus.S_RVALID !== 1'b1 || bus.S_RDATA !== model_read(32'h00))
      $display("FAIL collision_old_value rvalid=%b rdata=%h required 1/%h", bus.S_RVALID, bus.S_RDATA,
               model_read(32'h00));
    else checks_passed++;
    model_write(32'h00, 32'h5, 4'hF);
    checks_total++;
    if (regs_q[31:0] !== 32'h5 || bus.S_BVALID !== 1'b1)
      $display("FAIL collision_commit reg0=%h bvalid=%b required 00000005/1", regs_q[31:0], bus.S_BVALID);
    else checks_passed++;
    bus.S_BREADY = 1'b1; bus.S_RREADY = 1'b1;
    tick();
    bus.S_BREADY = 1'b0; bus.S_RREADY = 1'b0;
    $display("WR addr=00000000 data=00000005 strb=f with same-edge RD");
    axi_read(32'h00, data, resp, wait_cycles);
    checks_total++;
    if (data !== 32'h5 || resp !== 2'b00)
      $display("FAIL collision_followup rdata=%h rresp=%b required 00000005/00", data, resp);
    else checks_passed++;
  endtask

  task automatic test_backpressure();
    logic [31:0] addr, wdata;
    logic stable;
    addr  = 32'($urandom_range(0, NUM_REGS - 1)) * 4;
    wdata = $urandom;
    bus.S_AWADDR = addr; bus.S_WDATA = wdata; bus.S_WSTRB = 4'hF;
    bus.S_AWVALID = 1'b1; bus.S_WVALID = 1'b1; bus.S_BREADY = 1'b0;
    tick();
    bus.S_AWVALID = 1'b0; bus.S_WVALID = 1'b0;
    tick();
    model_write(addr, wdata, 4'hF);
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (bus.S_BVALID !== 1'b1 || bus.S_BRESP !== 2'b00) stable = 1'b0;
      tick();
    end
    checks_total++;
    if (!stable || bus.S_BVALID !== 1'b1)
      $display("FAIL b_stall_stable bvalid=%b bresp=%b required held 1/00", bus.S_BVALID, bus.S_BRESP);
    else checks_passed++;
    bus.S_BREADY = 1'b1;
    tick();
    bus.S_BREADY = 1'b0;
    checks_total++;
    if (bus.S_BVALID !== 1'b0) $display("FAIL b_release bvalid=%b required 0", bus.S_BVALID);
    else checks_passed++;
    $display("WR addr=%h data=%h strb=f stalled B 5 cycles", addr, wdata);
    bus.S_ARADDR = addr; bus.S_ARVALID = 1'b1; bus.S_RREADY = 1'b0;
    tick();
    bus.S_ARVALID = 1'b0;
    bus.S_ARADDR = 32'h0;
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (bus.S_RVALID !== 1'b1 || bus.S_RDATA !== model_read(addr) || bus.S_RRESP !== 2'b00 ||
          bus.S_ARREADY !== 1'b0) stable = 1'b0;
      tick();
    end
    checks_total++;
    if (!stable || bus.S_RDATA !== model_read(addr))
      $display("FAIL r_stall_stable rvalid=%b rdata=%h required held 1/%h", bus.S_RVALID, bus.S_RDATA,
               model_read(addr));
    else checks_passed++;
    bus.S_RREADY = 1'b1;
    tick();
    bus.S_RREADY = 1'b0;
    checks_total++;
    if (bus.S_RVALID !== 1'b0 || bus.S_ARREADY !== 1'b1)
      $display("FAIL r_release rvalid=%b arready=%b required 0/1", bus.S_RVALID, bus.S_ARREADY);
    else checks_passed++;
    $display("RD addr=%h rdata=%h stalled R 5 cycles", addr, model_read(addr));
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] wdata;
    logic quiet;
    bus.S_AWADDR = 32'h0C; bus.S_AWVALID = 1'b1; bus.S_BREADY = 1'b1;
    tick();
    bus.S_AWVALID = 1'b0;
    #2;
    ARESETN = 1'b0;
    #1;
    for (int i = 0; i < NUM_REGS; i++) model_regs[i] = 32'h0;
    checks_total++;
    if (regs_q !== model_flat() || bus.S_AWREADY !== 1'b0 || bus.S_BVALID !== 1'b0)
      $display("FAIL reset_mid_write regs_q=%h awready=%b bvalid=%b required 0/0/0",
               regs_q, bus.S_AWREADY, bus.S_BVALID);
    else checks_passed++;
    tick();
    #2;
    ARESETN = 1'b1;
    tick();
    wdata = $urandom;
    bus.S_WDATA = wdata; bus.S_WSTRB = 4'hF; bus.S_WVALID = 1'b1;
    tick();
    bus.S_WVALID = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (bus.S_BVALID !== 1'b0 || regs_q !== model_flat()) quiet = 1'b0;
      tick();
    end
    checks_total++;
    if (!quiet)
      $display("FAIL held_addr_discarded bvalid=%b regs_q=%h required 0/%h", bus.S_BVALID, regs_q, model_flat());
    else checks_passed++;
    bus.S_AWADDR = 32'h10; bus.S_AWVALID = 1'b1;
    tick();
    bus.S_AWVALID = 1'b0;
    tick();
    model_write(32'h10, wdata, 4'hF);
    checks_total++;
    if (bus.S_BVALID !== 1'b1 || regs_q !== model_flat())
      $display("FAIL post_reset_write bvalid=%b regs_q=%h required 1/%h", bus.S_BVALID, regs_q, model_flat());
    else checks_passed++;
    tick();
    bus.S_BREADY = 1'b0;
    $display("WR addr=00000010 data=%h strb=f after reset pulse", wdata);
  endtask

  task automatic test_random();
    logic [31:0] addr, wdata, rdata;
    logic [3:0] strb;
    logic [1:0] resp;
    int wait_cycles;
    for (int i = 0; i < 40; i++) begin
      addr = 32'($urandom_range(0, 19)) * 4 + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) begin
        wdata = $urandom;
        strb  = 4'($urandom_range(0, 15));
        axi_write(addr, wdata, strb, resp, wait_cycles);
        model_write(addr, wdata, strb);
        checks_total++;
        if (resp !== model_resp(addr) || wait_cycles !== 1 || regs_q !== model_flat())
          $display("FAIL rand_write addr=%h bresp=%b b_wait=%0d regs_q=%h required %b/1/%h",
                   addr, resp, wait_cycles, regs_q, model_resp(addr), model_flat());
        else checks_passed++;
      end else begin
        axi_read(addr, rdata, resp, wait_cycles);
        checks_total++;
        if (rdata !== model_read(addr) || resp !== model_resp(addr) || wait_cycles !== 0)
          $display("FAIL rand_read addr=%h rdata=%h rresp=%b r_wait=%0d required %h/%b/0",
                   addr, rdata, resp, wait_cycles, model_read(addr), model_resp(addr));
        else checks_passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_same_cycle();
    test_w_before_aw();
    test_strobe();
    test_out_of_range();
    test_collision();
    test_backpressure();
    test_reset_mid_write();
    test_random();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete, passed=%0d total=%0d", checks_passed, checks_total);
    $fatal(1, "watchdog expired");
  end
endmodule
